lsu_byte_master: RTL

//  Load/store initiator between the core's memory stage and a byte-wide data memory port.

---
 rtl/lsu_byte_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_master.sv
// Load/store initiator: serialises lb/lh/lw/lbu/lhu/sb/sh/sw requests into
// little-endian single-byte memory accesses and returns extended load data.
module lsu_byte_master #(
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          is_store,
   input  logic [2:0]    func3,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          done,
   output logic          err,
   output logic [31:0]   rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          store_q, store_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   asm_q, asm_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          legal;
   logic [1:0]    last_cnt;
   logic [31:0]   ext;

   // Load forms are legal either way; unsigned forms only exist for loads.
   always_comb begin
      legal = 1'b0;
      unique case (func3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~is_store;
         default:                legal = 1'b0;
      endcase
   end

   always_comb begin
      last_cnt = 2'd3;
      unique case (f3_q[1:0])
         2'b00:   last_cnt = 2'd0;
         2'b01:   last_cnt = 2'd1;
         default: last_cnt = 2'd3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ext     = 32'd0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               store_d = is_store;
               f3_d    = func3;
               addr_d  = addr;
               wdata_d = wdata;
               cnt_d   = 2'd0;
               asm_d   = 32'd0;
               if (legal) begin
                  err_d   = 1'b0;
                  state_d = StXfer;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
                  state_d = StDone;
               end
            end
         end
         StXfer: begin
            if (!store_q) begin
               asm_d[8*cnt_q +: 8] = mem_rdata;
            end
            // Extension works on the merged value so the last byte is included.
            unique case (f3_q)
               3'b000:  ext = {{24{asm_d[7]}}, asm_d[7:0]};
               3'b001:  ext = {{16{asm_d[15]}}, asm_d[15:0]};
               3'b100:  ext = {24'd0, asm_d[7:0]};
               3'b101:  ext = {16'd0, asm_d[15:0]};
               default: ext = asm_d;
            endcase
            if (cnt_q == last_cnt) begin
               state_d = StDone;
               if (!store_q) begin
                  rdata_d = ext;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         store_q <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         asm_q   <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      req_ready = (state_q == StIdle);
      done      = (state_q == StDone);
      err       = (state_q == StDone) & err_q;
      rdata     = rdata_q;
      mem_re    = (state_q == StXfer) & ~store_q;
      mem_we    = (state_q == StXfer) & store_q;
      mem_addr  = '0;
      mem_wdata = 8'd0;
      if (state_q == StXfer) begin
         mem_addr = addr_q + AW'(cnt_q);
      end
      if (mem_we) begin
         mem_wdata = wdata_q[8*cnt_q +: 8];
      end
   end

endmodule
